// File: rtl/aes_ctrl_pkg.sv
// ============================================================================
// Module     : aes_ctrl_pkg
// Description: Shared types and constants for the AES round sequencer.
//              Holds the state enum, the AES key-length constants and the
//              Nk-to-Nr decode.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } aes_state_t;

    localparam logic [7:0] NK_128 = 8'd4;
    localparam logic [7:0] NK_192 = 8'd6;
    localparam logic [7:0] NK_256 = 8'd8;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    // Unknown key lengths fall back to the longest schedule
    function automatic logic [3:0] nk_to_nr(input logic [7:0] nk);
        if (nk == NK_128)
            return NR_128;
        else if (nk == NK_192)
            return NR_192;
        else
            return NR_256;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aes_round_counter.sv
// ============================================================================
// Module     : aes_round_counter
// Description: Round index register with load/increment/clear, the latched
//              round count Nr and the last-full-round flag.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_counter
    import aes_ctrl_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic             i_clear,
    input  logic [7:0]       i_nk,
    output logic [IDX_W-1:0] o_rnd,
    output logic [IDX_W-1:0] o_nr,
    output logic             o_last_full
);

    logic [IDX_W-1:0] r_rnd;
    logic [IDX_W-1:0] r_nr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rnd <= '0;
            r_nr  <= IDX_W'(NR_128);
        end else if (i_load) begin
            r_rnd <= IDX_W'(1);
            r_nr  <= IDX_W'(nk_to_nr(i_nk));
        end else if (i_clear) begin
            r_rnd <= '0;
        end else if (i_inc) begin
            r_rnd <= r_rnd + 1'b1;
        end
    end

    assign o_rnd       = r_rnd;
    assign o_nr        = r_nr;
    assign o_last_full = (r_rnd == r_nr - 1'b1);

endmodule

`default_nettype wire

// File: rtl/aes_round_sequencer.sv
// ============================================================================
// Module     : aes_round_sequencer
// Description: Drives a shared combinational AES round datapath over Nr
//              iterations per block (AES-128/192/256) with valid/ready I/O.
//              Optional abort port enabled by defining AES_ABORT_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_sequencer
    import aes_ctrl_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
`ifdef AES_ABORT_EN
    input  logic              abort,
`endif
    input  logic [7:0]        nk,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_block,
    output logic [IDX_W-1:0]  key_idx,
    input  logic [DATA_W-1:0] round_key,
    output logic [DATA_W-1:0] rnd_state,
    output logic              rnd_mix_en,
    input  logic [DATA_W-1:0] rnd_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_block,
    output logic              busy
);

    aes_state_t        r_fsm;
    aes_state_t        w_fsm_nxt;
    logic [DATA_W-1:0] r_state;
    logic [DATA_W-1:0] r_out_block;
    logic              r_out_valid;
    logic              w_accept;
    logic              w_run;
    logic              w_final;
    logic              w_abort;
    logic              w_last_full;
    logic [IDX_W-1:0]  w_rnd;
    logic [IDX_W-1:0]  w_nr;

`ifdef AES_ABORT_EN
    // DONE already holds a committed result, so abort only cancels in-flight rounds
    assign w_abort = abort && ((r_fsm == ROUND) || (r_fsm == FINAL));
`else
    assign w_abort = 1'b0;
`endif

    aes_round_counter #(
        .IDX_W (IDX_W)
    ) u_round_counter (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_accept),
        .i_inc       (w_run),
        .i_clear     (w_abort),
        .i_nk        (nk),
        .o_rnd       (w_rnd),
        .o_nr        (w_nr),
        .o_last_full (w_last_full)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_fsm <= IDLE;
        else
            r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_accept   = 1'b0;
        w_run      = 1'b0;
        w_final    = 1'b0;
        in_ready   = 1'b0;
        key_idx    = '0;
        rnd_mix_en = 1'b1;
        if (!reset) begin
            case (r_fsm)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        w_accept  = 1'b1;
                        w_fsm_nxt = ROUND;
                    end
                end
                ROUND: begin
                    key_idx = w_rnd;
                    if (w_abort) begin
                        w_fsm_nxt = IDLE;
                    end else begin
                        w_run = 1'b1;
                        if (w_last_full)
                            w_fsm_nxt = FINAL;
                    end
                end
                FINAL: begin
                    key_idx    = w_nr;
                    rnd_mix_en = 1'b0;
                    if (w_abort) begin
                        w_fsm_nxt = IDLE;
                    end else begin
                        w_final   = 1'b1;
                        w_fsm_nxt = DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        w_fsm_nxt = IDLE;
                end
                default: w_fsm_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= '0;
            r_out_block <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept)
                r_state <= in_block ^ round_key;
            else if (w_run)
                r_state <= rnd_result;
            else if (w_abort)
                r_state <= '0;

            if (w_final) begin
                r_out_block <= rnd_result;
                r_out_valid <= 1'b1;
            end else if ((r_fsm == DONE) && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign rnd_state = r_state;
    assign out_valid = r_out_valid;
    assign out_block = r_out_block;
    assign busy      = (r_fsm != IDLE) && !reset;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
// ============================================================================
// Module     : tb_aes_round_sequencer
// Description: Directed bench for aes_round_sequencer with a behavioural AES
//              round, key schedule store and FIPS-197 Appendix C vectors.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes_round_sequencer;

    logic         clk;
    logic         reset;
    logic [7:0]   nk;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [3:0]   key_idx;
    logic [127:0] round_key;
    logic [127:0] rnd_state;
    logic         rnd_mix_en;
    logic [127:0] rnd_result;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         busy;
`ifdef AES_ABORT_EN
    logic         abort;
`endif

    logic [7:0]   sbox_t [256];
    logic [127:0] rk_mem [15];
    int           cyc;
    int           n_assert;
    int           n_fail;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_round_sequencer #(
        .DATA_W (128),
        .IDX_W  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef AES_ABORT_EN
        .abort      (abort),
`endif
        .nk         (nk),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_block   (in_block),
        .key_idx    (key_idx),
        .round_key  (round_key),
        .rnd_state  (rnd_state),
        .rnd_mix_en (rnd_mix_en),
        .rnd_result (rnd_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_block  (out_block),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Byte i of the block is bits [127-8i -: 8]; state column c holds bytes 4c..4c+3
    function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic [127:0] k, input logic mix);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                b[rw+4*c] = a[rw+4*((c+rw)%4)];
        if (mix) begin
            for (int c = 0; c < 4; c++) begin
                a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
                b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r ^ k;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int nr);
        logic [127:0] s;
        s = pt ^ rk_mem[0];
        for (int r = 1; r < nr; r++) s = aes_rnd(s, rk_mem[r], 1'b1);
        return aes_rnd(s, rk_mem[nr], 1'b0);
    endfunction

    assign round_key  = rk_mem[key_idx];
    assign rnd_result = aes_rnd(rnd_state, round_key, rnd_mix_en);

    task automatic load_keys(input logic [255:0] key, input int nkw);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nr;
        nr = (nkw == 4) ? 10 : (nkw == 6) ? 12 : 14;
        for (int i = 0; i < nkw; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = nkw; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nkw == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nkw > 6 && i % nkw == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nkw] ^ t;
        end
        for (int k = 0; k < 15; k++)
            rk_mem[k] = (k <= nr) ? {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]} : 128'h0;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accepts one block, then waits for out_valid without completing the handshake
    task automatic run_block(input string tag, input logic [7:0] nkv, input logic [127:0] exp_ct, input int exp_lat);
        int         c0;
        int         nfin;
        logic [3:0] kfin;
        bit         seen;
        chk({tag, " in_ready idle"}, in_ready, 1);
        in_block = PT;
        nk       = nkv;
        in_valid = 1'b1;
        c0       = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        nk       = (nkv == 8'd4) ? 8'd8 : 8'd4;
        chk({tag, " busy"}, busy, 1);
        seen = 1'b0;
        nfin = 0;
        kfin = 4'h0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            if (!rnd_mix_en) begin
                nfin++;
                kfin = key_idx;
            end
            @(negedge clk);
        end
        chk({tag, " out_valid seen"}, seen, 1);
        chk({tag, " latency"}, cyc - c0 - 1, exp_lat);
        chk({tag, " out_block"}, out_block, exp_ct);
        chk({tag, " final rounds"}, nfin, 1);
        chk({tag, " final key_idx"}, kfin, exp_lat);
    endtask

    task automatic finish_block(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " out_valid dropped"}, out_valid, 0);
        chk({tag, " back to idle"}, {busy, in_ready}, 2'b01);
    endtask

    task automatic wait_key_idx(input string tag, input logic [3:0] idx);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (key_idx == idx && busy) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, " reached round"}, hit, 1);
    endtask

    task automatic expect_quiet(input string tag);
        bit quiet;
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        chk({tag, " no out_valid"}, quiet, 1);
    endtask

    initial begin
        logic [127:0] pts  [4];
        logic [127:0] exps [4];
        int           acc_c [4];
        int           na;
        int           no;
        bit           acc;
        bit           stable;
        bit           rdy0;

        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv;
            inv = 8'h00;
            if (v != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gm(inv, 8'(v));
            end
            sbox_t[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        cyc       = 0;
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        nk        = 8'd4;
        in_valid  = 1'b0;
        in_block  = '0;
        out_ready = 1'b0;
`ifdef AES_ABORT_EN
        abort     = 1'b0;
`endif
        load_keys(KEY128, 4);

        repeat (3) @(negedge clk);
        chk("reset in_ready", in_ready, 0);
        chk("reset busy", busy, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_block", out_block, 0);
        chk("reset rnd_state", rnd_state, 0);
        chk("reset key_idx/mix_en", {key_idx, rnd_mix_en}, 5'b0000_1);
        reset = 1'b0;
        @(negedge clk);

        // AES-128 known-answer, then held under backpressure
        run_block("aes128", 8'd4, CT128, 10);
        stable = 1'b1;
        rdy0   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_block !== CT128 || out_valid !== 1'b1) stable = 1'b0;
            if (in_ready !== 1'b0) rdy0 = 1'b0;
        end
        chk("backpressure out_block stable", stable, 1);
        chk("backpressure in_ready low", rdy0, 1);
        finish_block("backpressure");

        // Four back-to-back AES-128 blocks with both sides always ready
        pts[0] = PT;
        pts[1] = ~PT;
        pts[2] = 128'h3243f6a8885a308d313198a2e0370734;
        pts[3] = 128'h0;
        for (int i = 0; i < 4; i++) exps[i] = aes_ref(pts[i], 10);
        chk("model matches FIPS C.1", exps[0], CT128);
        nk        = 8'd4;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_block  = pts[0];
        na        = 0;
        no        = 0;
        for (int i = 0; i < 200 && no < 4; i++) begin
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                chk("b2b result", out_block, exps[no]);
                no++;
            end
            if (acc) begin
                acc_c[na] = cyc + 1;
                na++;
            end
            @(negedge clk);
            if (acc) begin
                if (na < 4) in_block = pts[na];
                else        in_valid = 1'b0;
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("b2b blocks delivered", no, 4);
        for (int i = 1; i < 4; i++) chk("b2b accept spacing", acc_c[i] - acc_c[i-1], 12);

        // AES-192 with nk toggled mid-block
        load_keys(KEY192, 6);
        run_block("aes192", 8'd6, CT192, 12);
        finish_block("aes192");

        // Reset at round 5 discards the block
        in_block = PT;
        nk       = 8'd6;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_key_idx("midreset", 4'd5);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset during reset", {busy, in_ready, out_valid}, 3'b000);
        reset = 1'b0;
        @(negedge clk);
        chk("midreset after reset", {busy, in_ready, out_valid}, 3'b010);
        expect_quiet("midreset");
        run_block("aes192 after reset", 8'd6, CT192, 12);
        finish_block("aes192 after reset");

        // AES-256
        load_keys(KEY256, 8);
        run_block("aes256", 8'd8, CT256, 14);
        finish_block("aes256");

`ifdef AES_ABORT_EN
        // abort held high in IDLE does not block the accept
        abort    = 1'b1;
        in_block = PT;
        nk       = 8'd8;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
        chk("abort idle ignored", busy, 1);
        wait_key_idx("abort", 4'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort to idle", {busy, in_ready, out_valid}, 3'b010);
        chk("abort state cleared", rnd_state, 0);
        expect_quiet("abort");

        run_block("abort in done", 8'd8, CT256, 14);
        abort = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort in done keeps result", {out_valid, out_block}, {1'b1, CT256});
        abort = 1'b0;
        finish_block("abort in done");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
